// File: rtl/systolic_array_ctrl.sv
// ============================================================================
//  Module      : systolic_array_ctrl
//  Description : Job sequencer for a 1xK weight-stationary systolic MAC column:
//                weight load, accumulator clear, streamed MAC, tagged results.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_array_ctrl #(
  parameter int MAC_NUM  = 10,
  parameter int ACCU_NUM = 5,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_shift_num,
  input  logic             act_valid,
  output logic             busy,
  output logic             done,
  output logic             PE_load_weight,
  output logic             PE_clear_acc,
  output logic             PE_mac_enable,
  output logic [7:0]       PE_res_shift_num,
  output logic [CNT_W-1:0] wet_idx,
  output logic [CNT_W-1:0] act_idx,
  output logic             act_ready,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_idx
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_W  = 3'd1;
  localparam logic [2:0] CLEAR   = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(MAC_NUM);
  localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(MAC_NUM - 1);
  localparam logic [CNT_W-1:0] K_CNT    = CNT_W'(ACCU_NUM);
  localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(ACCU_NUM - 1);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(MAC_NUM + ACCU_NUM - 1);

  // Reset asserts asynchronously but is released only on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n_int = rst_pipe[1];

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             busy_nx, done_nx, load_nx, clear_nx;
  logic [7:0]       shift_nx;
  logic [CNT_W-1:0] wet_nx, act_idx_nx, res_idx_nx;
  logic             in_compute, draining;

  assign cnt_inc    = cnt + 1'b1;
  assign in_compute = (state == COMPUTE);
  assign draining   = (cnt >= N_CNT);

  // The handshake strobes must react to act_valid in the same cycle so a
  // stall freezes the column immediately; they are gated by flopped state.
  assign PE_mac_enable = in_compute && (act_valid || draining);
  assign act_ready     = in_compute && act_valid && !draining;
  assign result_valid  = PE_mac_enable && (cnt >= K_CNT);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    done_nx    = 1'b0;
    load_nx    = 1'b0;
    clear_nx   = 1'b0;
    shift_nx   = PE_res_shift_num;
    wet_nx     = wet_idx;
    act_idx_nx = act_idx;
    res_idx_nx = result_idx;
    if (abort) begin
      state_nx   = IDLE;
      cnt_nx     = '0;
      wet_nx     = '0;
      act_idx_nx = '0;
      res_idx_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = LOAD_W;
            cnt_nx   = '0;
            load_nx  = 1'b1;
            wet_nx   = '0;
            shift_nx = cfg_shift_num;
          end
        end
        LOAD_W: begin
          if (cnt == K_LAST) begin
            state_nx = CLEAR;
            cnt_nx   = '0;
            clear_nx = 1'b1;
          end else begin
            cnt_nx  = cnt_inc;
            load_nx = 1'b1;
            wet_nx  = cnt_inc;
          end
        end
        CLEAR: begin
          state_nx   = COMPUTE;
          cnt_nx     = '0;
          act_idx_nx = '0;
          res_idx_nx = '0;
        end
        COMPUTE: begin
          if (PE_mac_enable) begin
            if (cnt == END_CNT) begin
              state_nx = DONE;
              cnt_nx   = '0;
              done_nx  = 1'b1;
            end else begin
              cnt_nx     = cnt_inc;
              act_idx_nx = (cnt_inc < N_CNT) ? cnt_inc : N_LAST;
              res_idx_nx = (cnt_inc >= K_CNT) ? (cnt_inc - K_CNT) : '0;
            end
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy_nx = (state_nx != IDLE);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state            <= IDLE;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      PE_load_weight   <= 1'b0;
      PE_clear_acc     <= 1'b0;
      PE_res_shift_num <= 8'd0;
      wet_idx          <= '0;
      act_idx          <= '0;
      result_idx       <= '0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      busy             <= busy_nx;
      done             <= done_nx;
      PE_load_weight   <= load_nx;
      PE_clear_acc     <= clear_nx;
      PE_res_shift_num <= shift_nx;
      wet_idx          <= wet_nx;
      act_idx          <= act_idx_nx;
      result_idx       <= res_idx_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
// ============================================================================
//  Module      : tb_systolic_array_ctrl
//  Description : Self-checking bench for systolic_array_ctrl with a result-index
//                scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_systolic_array_ctrl;

  localparam int MAC_NUM  = 10;
  localparam int ACCU_NUM = 5;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [7:0]       cfg_shift_num;
  logic             act_valid;
  logic             busy;
  logic             done;
  logic             PE_load_weight;
  logic             PE_clear_acc;
  logic             PE_mac_enable;
  logic [7:0]       PE_res_shift_num;
  logic [CNT_W-1:0] wet_idx;
  logic [CNT_W-1:0] act_idx;
  logic             act_ready;
  logic             result_valid;
  logic [CNT_W-1:0] result_idx;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_idx;

  systolic_array_ctrl #(
    .MAC_NUM (MAC_NUM),
    .ACCU_NUM(ACCU_NUM),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .cfg_shift_num   (cfg_shift_num),
    .act_valid       (act_valid),
    .busy            (busy),
    .done            (done),
    .PE_load_weight  (PE_load_weight),
    .PE_clear_acc    (PE_clear_acc),
    .PE_mac_enable   (PE_mac_enable),
    .PE_res_shift_num(PE_res_shift_num),
    .wet_idx         (wet_idx),
    .act_idx         (act_idx),
    .act_ready       (act_ready),
    .result_valid    (result_valid),
    .result_idx      (result_idx)
  );

  always #5 clk = ~clk;

  // Results must emerge exactly in the order queued when the job was launched.
  always @(negedge clk) begin
    if (reset_n && result_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_extra: result_idx=%0d but no result expected", result_idx);
      end else begin
        exp_idx = exp_q.pop_front();
        if (result_idx !== exp_idx) begin
          errors++;
          $display("FAIL result_idx: got %0d want %0d", result_idx, exp_idx);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job();
    for (int i = 0; i < MAC_NUM; i++) exp_q.push_back(CNT_W'(i));
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; act_valid = 1'b0; cfg_shift_num = 8'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, PE_load_weight, PE_clear_acc, PE_mac_enable, act_ready, result_valid} !== 7'd0 ||
        PE_res_shift_num !== 8'd0 || wet_idx !== '0 || act_idx !== '0 || result_idx !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b shift=%0d wet=%0d act=%0d res=%0d want all 0",
               busy, done, PE_res_shift_num, wet_idx, act_idx, result_idx);
    end
    reset_n = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b want 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_nominal();
    push_job();
    cfg_shift_num = 8'd2;
    for (int c = 0; c <= 23; c++) begin
      start = (c == 0); act_valid = 1'b1;
      @(negedge clk);
      checks += 6;
      if (busy !== (c >= 1 && c <= 22)) begin errors++; $display("FAIL nom_busy c%0d: got %b", c, busy); end
      if (PE_load_weight !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL nom_load c%0d: got %b", c, PE_load_weight); end
      if (PE_clear_acc !== (c == 6)) begin errors++; $display("FAIL nom_clear c%0d: got %b", c, PE_clear_acc); end
      if (PE_mac_enable !== (c >= 7 && c <= 21)) begin errors++; $display("FAIL nom_mac c%0d: got %b", c, PE_mac_enable); end
      if (result_valid !== (c >= 12 && c <= 21)) begin errors++; $display("FAIL nom_rvalid c%0d: got %b", c, result_valid); end
      if (done !== (c == 22)) begin errors++; $display("FAIL nom_done c%0d: got %b", c, done); end
      if (c >= 1 && c <= 5) begin
        checks++;
        if (wet_idx !== CNT_W'(c - 1)) begin errors++; $display("FAIL nom_wet_idx c%0d: got %0d want %0d", c, wet_idx, c - 1); end
      end
      if (c >= 7 && c <= 21) begin
        checks += 2;
        if (act_ready !== (c <= 16)) begin errors++; $display("FAIL nom_act_ready c%0d: got %b", c, act_ready); end
        if (act_idx !== CNT_W'((c <= 16) ? c - 7 : MAC_NUM - 1)) begin
          errors++; $display("FAIL nom_act_idx c%0d: got %0d", c, act_idx);
        end
      end
      next_cycle();
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL nom_result_count: %0d results missing, want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    push_job();
    for (int c = 0; c <= 26; c++) begin
      start = (c == 0); act_valid = !(c >= 11 && c <= 13);
      @(negedge clk);
      checks += 4;
      if (PE_mac_enable !== ((c >= 7 && c <= 10) || (c >= 14 && c <= 24))) begin
        errors++; $display("FAIL stall_mac c%0d: got %b", c, PE_mac_enable);
      end
      if (act_ready !== ((c >= 7 && c <= 10) || (c >= 14 && c <= 19))) begin
        errors++; $display("FAIL stall_act_ready c%0d: got %b", c, act_ready);
      end
      if (result_valid !== (c >= 15 && c <= 24)) begin errors++; $display("FAIL stall_rvalid c%0d: got %b", c, result_valid); end
      if (done !== (c == 25)) begin errors++; $display("FAIL stall_done c%0d: got %b", c, done); end
      if (c >= 11 && c <= 14) begin
        checks++;
        if (act_idx !== CNT_W'(4)) begin errors++; $display("FAIL stall_act_idx_hold c%0d: got %0d want 4", c, act_idx); end
      end
      next_cycle();
    end
    start = 1'b0; act_valid = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_result_count: %0d missing, want 0", exp_q.size()); end
  endtask

  task automatic test_drain();
    push_job();
    for (int c = 0; c <= 23; c++) begin
      start = (c == 0); act_valid = (c <= 16);
      @(negedge clk);
      checks += 4;
      if (PE_mac_enable !== (c >= 7 && c <= 21)) begin errors++; $display("FAIL drain_mac c%0d: got %b", c, PE_mac_enable); end
      if (act_ready !== (c >= 7 && c <= 16)) begin errors++; $display("FAIL drain_act_ready c%0d: got %b", c, act_ready); end
      if (result_valid !== (c >= 12 && c <= 21)) begin errors++; $display("FAIL drain_rvalid c%0d: got %b", c, result_valid); end
      if (done !== (c == 22)) begin errors++; $display("FAIL drain_done c%0d: got %b", c, done); end
      if (c >= 16 && c <= 22) begin
        checks++;
        if (act_idx !== CNT_W'(MAC_NUM - 1)) begin errors++; $display("FAIL drain_act_idx c%0d: got %0d want 9", c, act_idx); end
      end
      next_cycle();
    end
    start = 1'b0; act_valid = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain_result_count: %0d missing, want 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    for (int c = 0; c <= 28; c++) begin
      start = (c == 0); abort = (c == 3); act_valid = 1'b1;
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (wet_idx !== CNT_W'(2) || PE_load_weight !== 1'b1) begin
          errors++; $display("FAIL abort_setup: wet_idx=%0d load=%b want 2/1", wet_idx, PE_load_weight);
        end
      end
      if (c >= 4) begin
        checks++;
        if ({busy, done, PE_load_weight, PE_clear_acc, PE_mac_enable, result_valid} !== 6'd0 || wet_idx !== '0) begin
          errors++; $display("FAIL abort_idle c%0d: busy=%b done=%b load=%b mac=%b wet=%0d want 0",
                             c, busy, done, PE_load_weight, PE_mac_enable, wet_idx);
        end
      end
      next_cycle();
    end
    start = 1'b1; abort = 1'b1;
    next_cycle();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_priority: busy=%b want 0", busy); end
    next_cycle();
    test_nominal();
  endtask

  task automatic test_start_shift();
    int dones = 0;
    push_job();
    for (int c = 0; c <= 30; c++) begin
      start = (c == 0 || c == 3 || c == 10 || c == 22);
      cfg_shift_num = (c < 8) ? 8'd7 : 8'd3;
      act_valid = 1'b1;
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (c >= 1) begin
        checks++;
        if (PE_res_shift_num !== 8'd7) begin errors++; $display("FAIL shift_hold c%0d: got %0d want 7", c, PE_res_shift_num); end
      end
      if (c >= 23) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_ignored c%0d: busy=%b want 0", c, busy); end
      end
      next_cycle();
    end
    start = 1'b0;
    checks += 2;
    if (dones != 1) begin errors++; $display("FAIL shift_done_count: got %0d want 1", dones); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL shift_result_count: %0d missing, want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    push_job();
    push_job();
    for (int c = 0; c <= 46; c++) begin
      start = (c == 0 || c == 23); act_valid = 1'b1;
      @(negedge clk);
      checks += 3;
      if (done !== (c == 22 || c == 45)) begin errors++; $display("FAIL b2b_done c%0d: got %b", c, done); end
      if (PE_load_weight !== ((c >= 1 && c <= 5) || (c >= 24 && c <= 28))) begin
        errors++; $display("FAIL b2b_load c%0d: got %b", c, PE_load_weight);
      end
      if (busy !== ((c >= 1 && c <= 22) || (c >= 24 && c <= 45))) begin
        errors++; $display("FAIL b2b_busy c%0d: got %b", c, busy);
      end
      next_cycle();
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_result_count: %0d missing, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    push_job();
    cfg_shift_num = 8'd5;
    for (int c = 0; c <= 10; c++) begin
      start = (c == 0); act_valid = 1'b1;
      if (c < 10) next_cycle();
    end
    start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, PE_load_weight, PE_clear_acc, PE_mac_enable, act_ready, result_valid} !== 7'd0 ||
        PE_res_shift_num !== 8'd0 || wet_idx !== '0 || act_idx !== '0 || result_idx !== '0) begin
      errors++;
      $display("FAIL reset_mid_compute: busy=%b mac=%b act_ready=%b shift=%0d act=%0d want all 0",
               busy, PE_mac_enable, act_ready, PE_res_shift_num, act_idx);
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || PE_mac_enable !== 1'b0) begin
      errors++; $display("FAIL reset_mid_release: busy=%b mac=%b want 0/0", busy, PE_mac_enable);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_drain();
    test_abort();
    test_start_shift();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
